// File: rtl/uart_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_boot_loader_pkg
//   Shared definitions for the UART boot loader: protocol byte values, the
//   loader state encoding and a small helper deciding when the loader is busy.
// -----------------------------------------------------------------------------
package uart_boot_loader_pkg;

  // Protocol bytes
  localparam logic [7:0] BOOT_MAGIC = 8'hA5;  // start-of-frame marker
  localparam logic [7:0] BOOT_ACK   = 8'h06;  // frame loaded, checksum good
  localparam logic [7:0] BOOT_NAK   = 8'h15;  // frame rejected

  // Loader states
  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    LEN_LO     = 3'd1,
    LEN_HI     = 3'd2,
    DATA       = 3'd3,
    CHECK      = 3'd4,
    ACK        = 3'd5,
    NAK        = 3'd6,
    RUN        = 3'd7
  } boot_state_t;

  // Busy spans the whole frame, from the accepted magic byte until the
  // ACK/NAK response has been taken by the transmitter.
  function automatic logic is_busy(input boot_state_t s);
    return (s != WAIT_MAGIC) && (s != RUN);
  endfunction

  // States in which inter-byte silence is policed.
  function automatic logic is_timed(input boot_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
//   Receives a program image from the UART receive core, writes it word by
//   word into the instruction/data BRAM and holds the CPU in reset until the
//   image is loaded. Each frame is answered with ACK or NAK. With no frame
//   inside the boot window the CPU is released to run what the BRAM holds.
//
//   Frame: A5, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CHK
//          where CHK is the 8-bit sum of the data bytes.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_rx_data   received byte, valid while i_rx_valid
//   i_rx_valid  single-cycle receive strobe
//   o_tx_data   response byte (ACK/NAK), stable while o_tx_valid
//   o_tx_valid  response request, held until i_tx_ready
//   i_tx_ready  transmitter accepts the response
//   o_mem_addr  BRAM word address
//   o_mem_data  BRAM write data
//   o_mem_wr    byte write enables, 4'hF for one cycle per word or 4'h0
//   o_cpu_rst   CPU reset request, low only once running
//   o_busy      frame in progress
//   o_error     sticky error: set by NAK, cleared by ACK
// -----------------------------------------------------------------------------
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int TIMEOUT    = 1000000,
  parameter int BOOT_WAIT  = 50000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic [3:0]            o_mem_wr,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam int MEM_WORDS = 2 ** ADDR_WIDTH;
  localparam int TO_W      = $clog2(TIMEOUT + 1);
  localparam int BW_W      = $clog2(BOOT_WAIT + 1);

  localparam logic [16:0]     MEM_WORDS_L = 17'(MEM_WORDS);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [BW_W-1:0] BW_LAST     = BW_W'(BOOT_WAIT - 1);

  boot_state_t           state_q,    state_d;
  logic [BW_W-1:0]       boot_cnt_q, boot_cnt_d;
  logic [TO_W-1:0]       silence_q,  silence_d;
  logic [15:0]           len_q,      len_d;       // word count N
  logic [15:0]           word_idx_q, word_idx_d;  // next word to write
  logic [1:0]            lane_q,     lane_d;      // next byte lane
  logic [23:0]           word_buf_q, word_buf_d;  // lanes 0..2 of current word
  logic [7:0]            chk_q,      chk_d;
  logic                  error_q,    error_d;
  logic [3:0]            mem_wr_q,   mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic [15:0]           len_rx;                  // length as seen with LEN_HI

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset is checked ahead of everything else, so a byte
    // (even a 4th data byte) arriving with reset is simply discarded and no
    // write strobe is produced.
    if (i_rst) begin
      // NOTE: non-blocking assignments throughout; every register updates
      // from the values present before the edge, independent of order here.
      state_q    <= WAIT_MAGIC;
      boot_cnt_q <= '0;
      silence_q  <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      lane_q     <= '0;
      word_buf_q <= '0;
      chk_q      <= '0;
      error_q    <= 1'b0;
      mem_wr_q   <= 4'h0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      silence_q  <= silence_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      lane_q     <= lane_d;
      word_buf_q <= word_buf_d;
      chk_q      <= chk_d;
      error_q    <= error_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign len_rx = {i_rx_data, len_q[7:0]};

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d is given its default before any branch, so each path
    // through this block assigns it and no latch can be inferred.
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    silence_d  = silence_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    lane_d     = lane_q;
    word_buf_d = word_buf_q;
    chk_d      = chk_q;
    error_d    = error_q;
    mem_wr_d   = 4'h0;        // write strobe lasts exactly one cycle
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      WAIT_MAGIC: begin
        // A magic byte takes priority over the boot window expiring.
        if (i_rx_valid && (i_rx_data == BOOT_MAGIC)) begin
          state_d    = LEN_LO;
          boot_cnt_d = '0;
          silence_d  = '0;
          chk_d      = '0;
          word_idx_d = '0;
          lane_d     = '0;
        end else if (boot_cnt_q == BW_LAST) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      LEN_LO: begin
        if (i_rx_valid) begin
          len_d[7:0] = i_rx_data;
          state_d    = LEN_HI;
        end
      end

      LEN_HI: begin
        if (i_rx_valid) begin
          len_d = len_rx;
          if ({1'b0, len_rx} > MEM_WORDS_L) begin
            state_d = NAK;
            error_d = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (i_rx_valid) begin
          chk_d  = chk_q + i_rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_buf_d[7:0]   = i_rx_data;
            2'd1: word_buf_d[15:8]  = i_rx_data;
            2'd2: word_buf_d[23:16] = i_rx_data;
            default: begin
              // Word complete: present it on the write port next cycle.
              mem_wr_d   = 4'hF;
              mem_addr_d = word_idx_q[ADDR_WIDTH-1:0];
              mem_data_d = {i_rx_data, word_buf_q};
              word_idx_d = word_idx_q + 16'd1;
              if (word_idx_q == (len_q - 16'd1)) state_d = CHECK;
            end
          endcase
        end
      end

      CHECK: begin
        if (i_rx_valid) begin
          if (i_rx_data == chk_q) begin
            state_d = ACK;
            error_d = 1'b0;
          end else begin
            state_d = NAK;
            error_d = 1'b1;
          end
        end
      end

      ACK: begin
        if (i_tx_ready) state_d = RUN;
      end

      NAK: begin
        // Back to waiting for a fresh frame with a full boot window.
        if (i_tx_ready) begin
          state_d    = WAIT_MAGIC;
          boot_cnt_d = '0;
        end
      end

      default: ;  // RUN: only reset leaves this state
    endcase

    // Inter-byte silence watchdog. A byte in the expiry cycle wins: it was
    // already consumed by the case above and the counter restarts.
    if (is_timed(state_q)) begin
      if (i_rx_valid) begin
        silence_d = '0;
      end else if (silence_q == TO_LAST) begin
        state_d = NAK;
        error_d = 1'b1;
      end else begin
        silence_d = silence_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_tx_valid = (state_q == ACK) || (state_q == NAK);
  assign o_tx_data  = (state_q == ACK) ? BOOT_ACK :
                      (state_q == NAK) ? BOOT_NAK : 8'h00;
  assign o_cpu_rst  = (state_q != RUN);
  assign o_busy     = is_busy(state_q);
  assign o_error    = error_q;
  assign o_mem_wr   = mem_wr_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_boot_loader
//   Directed bench for uart_boot_loader with ADDR_WIDTH=13, TIMEOUT=50,
//   BOOT_WAIT=100. Whole frames come from a vector table; timing corners
//   (boot window, silence timeout, handshake hold, reset mid-word) are
//   hand-written sequences. Inputs change on the falling edge, outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_boot_loader;

  localparam int ADDR_WIDTH = 13;

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic [7:0]            i_rx_data = 8'h00;
  logic                  i_rx_valid = 1'b0;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_data;
  logic [3:0]            o_mem_wr;
  logic                  o_cpu_rst;
  logic                  o_busy;
  logic                  o_error;

  always #5 i_clk = ~i_clk;

  uart_boot_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT   (50),
    .BOOT_WAIT (100)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data),
    .o_mem_wr  (o_mem_wr),
    .o_cpu_rst (o_cpu_rst),
    .o_busy    (o_busy),
    .o_error   (o_error)
  );

  int errors = 0;
  int checks = 0;

  // Write log captured from the BRAM port.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          bad_wr = 0;

  always @(negedge i_clk) begin
    if (o_mem_wr == 4'hF) begin
      wr_addr_q.push_back(32'(o_mem_addr));
      wr_data_q.push_back(o_mem_data);
    end else if (o_mem_wr != 4'h0) begin
      bad_wr++;
    end
  end

  // Frame vectors: bytes left-aligned in 'bytes', first byte in [127:120].
  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           n;
    logic [7:0]   exp_tx;
    int           exp_wr;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
    logic         exp_err;
    logic         exp_cpu_rst;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_tx_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    logic [127:0] bs;
    bs = v.bytes;
    for (int i = 0; i < v.n; i++) send_byte(bs[127-8*i -: 8]);
  endtask

  task automatic wait_tx(input string name);
    int n;
    n = 0;
    while (o_tx_valid !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check({name, ".tx_valid"}, 32'(o_tx_valid), 32'h1);
  endtask

  task automatic accept();
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    i_tx_ready = 1'b0;
  endtask

  function automatic logic [31:0] wr_addr(input int i);
    return (wr_addr_q.size() > i) ? wr_addr_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wr_data(input int i);
    return (wr_data_q.size() > i) ? wr_data_q[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic early;
    logic unstable;

    // Data bytes 11..88 sum to 0x264, so the good checksum is 0x64.
    vecs[0] = '{"good2",  {96'hA50200112233445566778864, 32'd0}, 12, 8'h06, 2,
                32'h44332211, 32'h88776655, 1'b0, 1'b0};
    vecs[1] = '{"badchk", {96'hA50200112233445566778865, 32'd0}, 12, 8'h15, 2,
                32'h44332211, 32'h88776655, 1'b1, 1'b1};
    vecs[2] = '{"lenbig", {24'hA50120, 104'd0}, 3, 8'h15, 0,
                32'h0, 32'h0, 1'b1, 1'b1};
    vecs[3] = '{"len0",   {32'hA5000000, 96'd0}, 4, 8'h06, 0,
                32'h0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{"len0bad", {32'hA5000001, 96'd0}, 4, 8'h15, 0,
                32'h0, 32'h0, 1'b1, 1'b1};
    vecs[5] = '{"junk1",  {80'h00FFA50100010203040A, 48'd0}, 10, 8'h06, 1,
                32'h04030201, 32'h0, 1'b0, 1'b0};

    // ---- reset values and boot window ----
    do_reset();
    check("rst.cpu_rst",  32'(o_cpu_rst),  32'h1);
    check("rst.tx_valid", 32'(o_tx_valid), 32'h0);
    check("rst.tx_data",  32'(o_tx_data),  32'h0);
    check("rst.mem_wr",   32'(o_mem_wr),   32'h0);
    check("rst.mem_addr", 32'(o_mem_addr), 32'h0);
    check("rst.mem_data", o_mem_data,      32'h0);
    check("rst.busy",     32'(o_busy),     32'h0);
    check("rst.error",    32'(o_error),    32'h0);

    early = 1'b0;
    unstable = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge i_clk);
      if (o_cpu_rst !== 1'b1) early = 1'b1;
      if (o_tx_valid !== 1'b0) unstable = 1'b1;
    end
    check("boot.held_99", 32'(early), 32'h0);
    @(negedge i_clk);
    check("boot.release_100", 32'(o_cpu_rst), 32'h0);
    check("boot.no_tx", 32'(unstable), 32'h0);
    check("boot.no_writes", 32'(wr_addr_q.size()), 32'h0);

    // ---- table of whole frames ----
    foreach (vecs[i]) begin
      do_reset();
      send_vec(vecs[i]);
      wait_tx(vecs[i].name);
      check({vecs[i].name, ".tx_data"}, 32'(o_tx_data), 32'(vecs[i].exp_tx));
      accept();
      check({vecs[i].name, ".tx_done"}, 32'(o_tx_valid), 32'h0);
      check({vecs[i].name, ".busy"},    32'(o_busy),     32'h0);
      check({vecs[i].name, ".error"},   32'(o_error),    32'(vecs[i].exp_err));
      check({vecs[i].name, ".cpu_rst"}, 32'(o_cpu_rst),  32'(vecs[i].exp_cpu_rst));
      check({vecs[i].name, ".nwr"}, 32'(wr_addr_q.size()), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr >= 1) begin
        check({vecs[i].name, ".w0.addr"}, wr_addr(0), 32'h0);
        check({vecs[i].name, ".w0.data"}, wr_data(0), vecs[i].exp_w0);
      end
      if (vecs[i].exp_wr >= 2) begin
        check({vecs[i].name, ".w1.addr"}, wr_addr(1), 32'h1);
        check({vecs[i].name, ".w1.data"}, wr_data(1), vecs[i].exp_w1);
      end
    end

    // ---- NAK then a good frame clears the error ----
    do_reset();
    send_vec(vecs[1]);
    wait_tx("retry.nak");
    check("retry.nak.data", 32'(o_tx_data), 32'h15);
    check("retry.nak.err",  32'(o_error),   32'h1);
    accept();
    send_vec(vecs[0]);
    wait_tx("retry.ack");
    check("retry.ack.data", 32'(o_tx_data), 32'h06);
    accept();
    check("retry.err_clr", 32'(o_error),   32'h0);
    check("retry.run",     32'(o_cpu_rst), 32'h0);
    check("retry.nwr",     32'(wr_addr_q.size()), 32'h4);
    check("retry.w3.data", wr_data(3), 32'h88776655);

    // ---- silence timeout, held response, dropped byte, boot restart ----
    do_reset();
    send_byte(8'hA5);
    check("to.busy", 32'(o_busy), 32'h1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    early = 1'b0;
    for (int k = 1; k < 50; k++) begin
      @(negedge i_clk);
      if (o_tx_valid !== 1'b0) early = 1'b1;
    end
    check("to.not_before_50", 32'(early), 32'h0);
    @(negedge i_clk);
    check("to.tx_valid", 32'(o_tx_valid), 32'h1);
    check("to.tx_data",  32'(o_tx_data),  32'h15);
    check("to.error",    32'(o_error),    32'h1);
    unstable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_rx_data  = 8'hA5;
      i_rx_valid = (k == 3);
      @(negedge i_clk);
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h15) unstable = 1'b1;
    end
    i_rx_valid = 1'b0;
    check("hold.stable", 32'(unstable), 32'h0);
    accept();
    check("hold.tx_done", 32'(o_tx_valid), 32'h0);
    check("hold.busy",    32'(o_busy),     32'h0);
    check("hold.error",   32'(o_error),    32'h1);
    early = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge i_clk);
      if (o_cpu_rst !== 1'b1) early = 1'b1;
    end
    check("reboot.held_99", 32'(early), 32'h0);
    @(negedge i_clk);
    check("reboot.release_100", 32'(o_cpu_rst), 32'h0);

    // ---- byte arriving in the expiry cycle wins ----
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (49) @(negedge i_clk);
    send_byte(8'h01);
    check("race.no_nak1", 32'(o_tx_valid), 32'h0);
    repeat (49) @(negedge i_clk);
    send_byte(8'h02);
    check("race.no_nak2", 32'(o_tx_valid), 32'h0);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0A);
    wait_tx("race");
    check("race.tx_data", 32'(o_tx_data), 32'h06);
    check("race.w0.data", wr_data(0), 32'h04030201);

    // ---- maximum length is accepted ----
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h20);
    @(negedge i_clk);
    check("lenmax.no_nak", 32'(o_tx_valid), 32'h0);
    check("lenmax.busy",   32'(o_busy),     32'h1);

    // ---- reset together with the 4th data byte ----
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    i_rx_data  = 8'h44;
    i_rx_valid = 1'b1;
    i_rst      = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_rst      = 1'b0;
    check("midrst.mem_wr",   32'(o_mem_wr),   32'h0);
    check("midrst.mem_data", o_mem_data,      32'h0);
    check("midrst.cpu_rst",  32'(o_cpu_rst),  32'h1);
    check("midrst.busy",     32'(o_busy),     32'h0);
    check("midrst.tx_valid", 32'(o_tx_valid), 32'h0);
    check("midrst.nwr",      32'(wr_addr_q.size()), 32'h0);
    send_vec(vecs[0]);
    wait_tx("midrst.reload");
    check("midrst.tx_data", 32'(o_tx_data), 32'h06);
    accept();
    check("midrst.w0.data", wr_data(0), 32'h44332211);
    check("midrst.w1.addr", wr_addr(1), 32'h1);
    check("midrst.w1.data", wr_data(1), 32'h88776655);

    check("mem_wr.only_F_or_0", 32'(bad_wr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
